uart_text_grid: RTL
===================

UART_TEXT_GRID -- requirements
Module: uart_text_grid

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of text rows, 2..16.
REQ-002 SHALL have parameter COLS, default 16: characters per row, power of two, 4..64.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic on posedge.
REQ-004 SHALL have port resetN, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port byteReady, input, 1 bit: one-cycle strobe marking a valid received byte.
REQ-006 SHALL have port dataIn, input, 8 bits: received byte, sampled when byteReady=1.
REQ-007 SHALL have port charAddress, input, $clog2(ROWS*COLS) bits: read address, row*COLS+col.
REQ-008 SHALL have port charOut, output, 8 bits: character at charAddress, registered.
REQ-009 SHALL have port cursorRow, output, $clog2(ROWS) bits: current write row.
REQ-010 SHALL have port cursorCol, output, $clog2(COLS) bits: current write column.
REQ-011 SHALL have port busy, output, 1 bit: high while a bulk CLEAR/SCROLL/BLANK sweep runs.
REQ-012 SHALL have port overflow, output, 1 bit: sticky; a byte was dropped.

Function
REQ-013 SHALL hold a ROWS*COLS x 8-bit character array; charOut = array[charAddress] one cycle after the address, always, including while busy.
REQ-014 SHALL latch dataIn into a one-entry pending register on byteReady if it is empty, or if it is being consumed in that same cycle.
REQ-015 SHALL drop byteReady arriving while pending is full and not consumed, and set overflow.
REQ-016 SHALL have FSM states IDLE, CLEAR, SCROLL, BLANK; pending is consumed only in IDLE, one byte per cycle.
REQ-017 SHALL handle printable bytes 0x20..0x7E by writing them at the cursor, then col+1.
REQ-018 SHALL treat col wrap (col was COLS-1) as a newline.
REQ-019 SHALL treat 0x0D (CR) as col=0 with row unchanged.
REQ-020 SHALL treat 0x0A (LF) as col=0 plus a newline.
REQ-021 SHALL treat 0x08 (BS) at col>0 as col-1 and write 0x20 at the new position; at col=0, no effect.
REQ-022 SHALL treat 0x0C (FF) as entering CLEAR.
REQ-023 SHALL ignore all other bytes; they are consumed with no effect.
REQ-024 SHALL advance the row on newline when row<ROWS-1; at row=ROWS-1, behaviour is per REQ-031/REQ-032.
REQ-025 SHALL, in CLEAR, write 0x20 to every cell, one per cycle, for ROWS*COLS cycles; then cursor=(0,0) and IDLE.
REQ-026 SHALL drive busy=1 in CLEAR, SCROLL and BLANK, and 0 in IDLE.
REQ-027 SHALL keep accepting bytes into pending while busy (REQ-014/REQ-015 apply).

Reset
REQ-028 SHALL, on resetN=0 at posedge, set charOut=0x20, cursor=(0,0), overflow=0, pending empty, state=CLEAR.
REQ-029 SHALL, after resetN returns high, run the full CLEAR sweep (busy=1 for ROWS*COLS cycles); no array contents survive reset.
REQ-030 SHALL treat reset asserted mid-sweep or mid-byte as aborting the operation and restarting per REQ-028.

Configuration
REQ-031 SHALL, with UART_TEXT_GRID_SCROLL_EN defined, handle newline at the last row by entering SCROLL, then BLANK:
- SCROLL copies row r+1 into row r for r=0..ROWS-2, one cell per cycle, (ROWS-1)*COLS cycles.
- BLANK writes 0x20 to row ROWS-1 for COLS cycles.
- Afterwards the cursor is (ROWS-1, 0).
REQ-032 SHALL, without UART_TEXT_GRID_SCROLL_EN, handle newline at the last row by moving the cursor to (0,0) with contents retained and no busy period; SCROLL and BLANK states are not synthesised.

Verification
REQ-033 SHALL cover reset: hold resetN=0 3 cycles, release -> busy=1 for exactly 64 cycles (defaults); then all 64 addresses read 0x20.
REQ-034 SHALL cover row wrap: send "A" x17 -> row0 all 0x41, cell 16=0x41, cursor=(1,1).
REQ-035 SHALL cover backspace: send "AB",0x08 -> cell0=0x41, cell1=0x20, cursor=(0,1); an extra 0x08,0x08 gives cursor=(0,0) with no further change.
REQ-036 SHALL cover last-row LF: send "X",0x0A,"Y",0x0A,"Z",0x0A,"W",0x0A.
- With macro: busy=1 for 64 cycles, then cell0=0x59, cell16=0x5A, cell32=0x57, row3 blank, cursor=(3,0).
- Without macro: no busy, cursor=(0,0), cell0=0x58.
REQ-037 SHALL cover overflow: send 0x0C, then 3 bytes on consecutive cycles during busy -> first byte retained, others dropped, overflow=1 until reset.
REQ-038 SHALL cover same-cycle consume/accept: byteReady on back-to-back cycles in IDLE -> no drop, overflow=0.

Source files
------------

// File: rtl/uart_text_grid.sv
// UART text grid: byte stream to ROWS x COLS character array with cursor control.
// Define UART_TEXT_GRID_SCROLL_EN to scroll on newline at the last row instead of wrapping.
module uart_text_grid #(
    parameter int ROWS = 4,
    parameter int COLS = 16
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            byteReady,
    input  logic [7:0]                      dataIn,
    input  logic [$clog2(ROWS*COLS)-1:0]    charAddress,
    output logic [7:0]                      charOut,
    output logic [$clog2(ROWS)-1:0]         cursorRow,
    output logic [$clog2(COLS)-1:0]         cursorCol,
    output logic                            busy,
    output logic                            overflow
);

    localparam int N  = ROWS * COLS;
    localparam int AW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

`ifdef UART_TEXT_GRID_SCROLL_EN
    typedef enum logic [1:0] {IDLE, CLEAR, SCROLL, BLANK} state_e;
`else
    typedef enum logic [1:0] {IDLE, CLEAR} state_e;
`endif

    state_e          state;
    logic [7:0]      mem [N];
    logic [AW-1:0]   sweepIdx;
    logic            pendValid;
    logic [7:0]      pendData;

    logic            consume;
    logic            isPrint, isCR, isLF, isBS, isFF;
    logic            colLast, rowLast, newLine;
    logic [AW-1:0]   cursorAddr;
    logic            we;
    logic [AW-1:0]   wAddr;
    logic [7:0]      wData;

    // COLS is a power of two, so the linear address is just {row, col}
    assign cursorAddr = {cursorRow, cursorCol};
    assign consume    = (state == IDLE) && pendValid;

    assign isPrint = (pendData >= 8'h20) && (pendData <= 8'h7E);
    assign isCR    = pendData == 8'h0D;
    assign isLF    = pendData == 8'h0A;
    assign isBS    = pendData == 8'h08;
    assign isFF    = pendData == 8'h0C;
    assign colLast = cursorCol == CW'(COLS - 1);
    assign rowLast = cursorRow == RW'(ROWS - 1);
    assign newLine = consume && (isLF || (isPrint && colLast));

    always_comb begin
        we    = 1'b0;
        wAddr = cursorAddr;
        wData = 8'h20;
        case (state)
            IDLE: begin
                if (pendValid && isPrint) begin
                    we    = 1'b1;
                    wData = pendData;
                end else if (pendValid && isBS && cursorCol != '0) begin
                    we    = 1'b1;
                    wAddr = {cursorRow, cursorCol - CW'(1)};
                end
            end
            CLEAR: begin
                we    = 1'b1;
                wAddr = sweepIdx;
            end
`ifdef UART_TEXT_GRID_SCROLL_EN
            SCROLL: begin
                we    = 1'b1;
                wAddr = sweepIdx;
                wData = mem[sweepIdx + AW'(COLS)];
            end
            BLANK: begin
                we    = 1'b1;
                wAddr = sweepIdx;
            end
`endif
            default: ;
        endcase
        if (!resetN) we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (we) mem[wAddr] <= wData;
    end

    always_ff @(posedge clk) begin
        if (!resetN) charOut <= 8'h20;
        else         charOut <= mem[charAddress];
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            sweepIdx  <= '0;
            cursorRow <= '0;
            cursorCol <= '0;
            pendValid <= 1'b0;
            pendData  <= '0;
            overflow  <= 1'b0;
        end else begin
            // one-entry buffer: refill allowed in the cycle it drains
            if (byteReady) begin
                if (!pendValid || consume) begin
                    pendValid <= 1'b1;
                    pendData  <= dataIn;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (consume) begin
                pendValid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pendValid) begin
                        unique case (1'b1)
                            isPrint: cursorCol <= cursorCol + CW'(1);
                            isCR, isLF: cursorCol <= '0;
                            isBS: begin
                                if (cursorCol != '0)
                                    cursorCol <= cursorCol - CW'(1);
                            end
                            isFF: begin
                                state    <= CLEAR;
                                busy     <= 1'b1;
                                sweepIdx <= '0;
                            end
                            default: ;
                        endcase
                    end
                    if (newLine) begin
                        if (!rowLast) begin
                            cursorRow <= cursorRow + RW'(1);
                        end else begin
`ifdef UART_TEXT_GRID_SCROLL_EN
                            state    <= SCROLL;
                            busy     <= 1'b1;
                            sweepIdx <= '0;
`else
                            cursorRow <= '0;
`endif
                        end
                    end
                end
                CLEAR: begin
                    sweepIdx <= sweepIdx + AW'(1);
                    if (sweepIdx == AW'(N - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sweepIdx  <= '0;
                        cursorRow <= '0;
                        cursorCol <= '0;
                    end
                end
`ifdef UART_TEXT_GRID_SCROLL_EN
                SCROLL: begin
                    sweepIdx <= sweepIdx + AW'(1);
                    if (sweepIdx == AW'((ROWS - 1) * COLS - 1))
                        state <= BLANK;
                end
                BLANK: begin
                    sweepIdx <= sweepIdx + AW'(1);
                    if (sweepIdx == AW'(N - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sweepIdx  <= '0;
                        cursorRow <= RW'(ROWS - 1);
                        cursorCol <= '0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
